sr_flag_arbiter: RTL and testbench

- Shares one set/clear access path to a bank of NFLAG SR-style flag flip-flops among NREQ requesters.
- Round-robin arbitration; one operation per two clock cycles.
- Drives a single s_out/r_out pair plus the flag select to mirror the SR drive on the bank.
- Holds the flag bank internally and guarantees the forbidden s=r=1 input is never produced.

---
 rtl/sr_flag_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbiter sharing one set/clear path to a bank of
// SR-style flag flops. Each granted operation takes two cycles: IDLE samples and
// arbitrates, APPLY drives s/r/flag_sel for one cycle, and the flag updates at
// the edge that ends APPLY.
// Optional feature macro: SR_TOGGLE_EN (op 2'b11 toggles the selected flag;
// when undefined, op 2'b11 is rejected with err).
module sr_flag_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NFLAG = 8,
    parameter int unsigned IDXW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_i,
    input  logic [2*NREQ-1:0]      op_i,
    input  logic [IDXW*NREQ-1:0]   idx_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic                   err_o,
    output logic                   s_out_o,
    output logic                   r_out_o,
    output logic [IDXW-1:0]        flag_sel_o,
    output logic [NFLAG-1:0]       flags_o,
    output logic [NFLAG-1:0]       flags_n_o
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] APPLY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic [PW-1:0]    winner_q, winner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             err_q, err_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic [IDXW-1:0]  sel_q, sel_d;
    logic [NFLAG-1:0] flags_q, flags_d;

    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [1:0]       win_op;
    logic [IDXW-1:0]  win_fidx;
    logic             win_in_range;
    logic             dec_s, dec_r, dec_err;

    // Round-robin search: first requester at or above the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!win_found && req_i[(32'(rr_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = PW'((32'(rr_q) + k) % NREQ);
            end
        end
    end

    // Mux out the winner's op and flag index.
    always_comb begin
        win_op   = 2'b00;
        win_fidx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                win_op   = op_i[2*i +: 2];
                win_fidx = idx_i[IDXW*i +: IDXW];
            end
        end
    end

    assign win_in_range = (32'(win_fidx) < NFLAG);

`ifdef SR_TOGGLE_EN
    logic win_flag;

    // Current state of the selected flag, needed to choose the toggle direction.
    always_comb begin
        win_flag = 1'b0;
        for (int unsigned j = 0; j < NFLAG; j++) begin
            if (win_fidx == IDXW'(j)) begin
                win_flag = flags_q[j];
            end
        end
    end
`endif

    // Decode the winner's op into an SR drive; s and r are mutually exclusive by construction.
    always_comb begin
        dec_s   = 1'b0;
        dec_r   = 1'b0;
        dec_err = 1'b0;
        if (!win_in_range) begin
            dec_err = 1'b1;
        end else begin
            case (win_op)
                2'b01: dec_s = 1'b1;
                2'b10: dec_r = 1'b1;
                2'b11: begin
`ifdef SR_TOGGLE_EN
                    dec_s = ~win_flag;
                    dec_r = win_flag;
`else
                    dec_err = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Next-state logic: outputs are only non-zero during APPLY.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        winner_d = winner_q;
        gnt_d    = '0;
        err_d    = 1'b0;
        s_d      = 1'b0;
        r_d      = 1'b0;
        sel_d    = '0;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = APPLY;
                    winner_d = win_idx;
                    gnt_d    = NREQ'(1) << win_idx;
                    err_d    = dec_err;
                    s_d      = dec_s;
                    r_d      = dec_r;
                    sel_d    = win_fidx;
                end
            end
            APPLY: begin
                state_d = IDLE;
                if (32'(winner_q) == NREQ - 1) begin
                    rr_d = '0;
                end else begin
                    rr_d = winner_q + 1'b1;
                end
                // s/r are already zero for rejected ops, so no extra err gating.
                for (int unsigned j = 0; j < NFLAG; j++) begin
                    if (sel_q == IDXW'(j)) begin
                        if (s_q) begin
                            flags_d[j] = 1'b1;
                        end else if (r_q) begin
                            flags_d[j] = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            winner_q <= '0;
            gnt_q    <= '0;
            err_q    <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            sel_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            winner_q <= winner_d;
            gnt_q    <= gnt_d;
            err_q    <= err_d;
            s_q      <= s_d;
            r_q      <= r_d;
            sel_q    <= sel_d;
            flags_q  <= flags_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign err_o      = err_q;
    assign s_out_o    = s_q;
    assign r_out_o    = r_q;
    assign flag_sel_o = sel_q;
    assign flags_o    = flags_q;
    assign flags_n_o  = ~flags_q;

    // The forbidden SR input combination must never reach the bank.
    a_no_sr_both : assert property (@(posedge clk) disable iff (!rst_n) !(s_out_o && r_out_o));

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Self-checking bench for sr_flag_arbiter (NREQ=4, NFLAG=6, IDXW=3).
// Honours SR_TOGGLE_EN in its expectations.
module tb_sr_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 6;
    localparam int IDXW  = 3;

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [2*NREQ-1:0] op;
    logic [IDXW*NREQ-1:0] idx;
    logic [NREQ-1:0]  gnt;
    logic             err;
    logic             s_out;
    logic             r_out;
    logic [IDXW-1:0]  flag_sel;
    logic [NFLAG-1:0] flags;
    logic [NFLAG-1:0] flags_n;

    int checks;
    int errors;

    // Reference model state: flag bank and round-robin pointer.
    bit m_flags [NFLAG];
    int m_rr;

    sr_flag_arbiter #(
        .NREQ  (NREQ),
        .NFLAG (NFLAG),
        .IDXW  (IDXW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .op_i       (op),
        .idx_i      (idx),
        .gnt_o      (gnt),
        .err_o      (err),
        .s_out_o    (s_out),
        .r_out_o    (r_out),
        .flag_sel_o (flag_sel),
        .flags_o    (flags),
        .flags_n_o  (flags_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pack_idx(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NFLAG; i++) m_flags[i] = 1'b0;
        m_rr = 0;
    endtask

    function automatic int m_winner(input logic [3:0] rq);
        for (int k = 0; k < NREQ; k++) begin
            if (rq[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    // Expected APPLY-cycle view: {gnt, s_out, r_out, err, flag_sel}.
    function automatic logic [9:0] m_apply(input int w, input logic [7:0] ops,
                                           input logic [11:0] ixs);
        logic [1:0] o;
        int         ix;
        logic       s, r, e;
        o  = ops[2*w +: 2];
        ix = int'(ixs[3*w +: 3]);
        s  = 1'b0;
        r  = 1'b0;
        e  = (ix >= NFLAG);
        if (!e) begin
            if (o == 2'd1) s = 1'b1;
            else if (o == 2'd2) r = 1'b1;
            else if (o == 2'd3) begin
`ifdef SR_TOGGLE_EN
                s = !m_flags[ix];
                r = m_flags[ix];
`else
                e = 1'b1;
`endif
            end
        end
        return {4'(1 << w), s, r, e, 3'(ix)};
    endfunction

    task automatic m_commit(input int w, input logic [9:0] e);
        if (e[5]) m_flags[e[2:0]] = 1'b1;
        else if (e[4]) m_flags[e[2:0]] = 1'b0;
        m_rr = (w + 1) % NREQ;
    endtask

    function automatic logic [NFLAG-1:0] m_vec();
        logic [NFLAG-1:0] v;
        for (int i = 0; i < NFLAG; i++) v[i] = m_flags[i];
        return v;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; op = '0; idx = '0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One request/grant round: captures the APPLY view, then flags and gnt after APPLY.
    task automatic txn(input logic [3:0] rq, input logic [7:0] ops, input logic [11:0] ixs,
                       output logic [9:0] a, output logic [5:0] f, output logic [3:0] g2);
        @(negedge clk);
        req = rq; op = ops; idx = ixs;
        @(posedge clk);
        #1;
        a = {gnt, s_out, r_out, err, flag_sel};
        @(negedge clk);
        req = '0; op = '0; idx = '0;
        @(posedge clk);
        #1;
        f  = flags;
        g2 = gnt;
    endtask

    task automatic test_reset();
        logic [9:0] a;
        logic [5:0] f;
        logic [3:0] g2;
        logic [16:0] obs;
        txn(4'b0001, 8'b01, pack_idx(1, 0, 0, 0), a, f, g2);
        checks++;
        if (f !== 6'h02) begin
            errors++;
            $display("FAIL reset_preset_flag: got %h, expected %h", f, 6'h02);
        end
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        obs = {flags, flags_n, gnt, err};
        checks++;
        if (obs !== {6'h00, 6'h3F, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got %h, expected %h", obs, {6'h00, 6'h3F, 4'h0, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({gnt, err, s_out, r_out, flag_sel, flags, flags_n} !==
                {4'h0, 3'b000, 3'd0, 6'h00, 6'h3F}) begin
                errors++;
                $display("FAIL reset_idle_hold cycle %0d: got %h, expected %h", c,
                         {gnt, err, s_out, r_out, flag_sel, flags, flags_n},
                         {4'h0, 3'b000, 3'd0, 6'h00, 6'h3F});
            end
        end
    endtask

    task automatic test_set_clear();
        logic [9:0] a;
        logic [5:0] f;
        logic [3:0] g2;
        txn(4'b0001, 8'b01, pack_idx(3, 0, 0, 0), a, f, g2);
        checks++;
        if (a !== {4'b0001, 1'b1, 1'b0, 1'b0, 3'd3}) begin
            errors++;
            $display("FAIL set_apply: got %h, expected %h", a, {4'b0001, 3'b100, 3'd3});
        end
        checks++;
        if ({f, g2} !== {6'h08, 4'h0}) begin
            errors++;
            $display("FAIL set_flags: got %h, expected %h", {f, g2}, {6'h08, 4'h0});
        end
        txn(4'b0001, 8'b10, pack_idx(3, 0, 0, 0), a, f, g2);
        checks++;
        if (a !== {4'b0001, 1'b0, 1'b1, 1'b0, 3'd3}) begin
            errors++;
            $display("FAIL clear_apply: got %h, expected %h", a, {4'b0001, 3'b010, 3'd3});
        end
        checks++;
        if (f !== 6'h00) begin
            errors++;
            $display("FAIL clear_flags: got %h, expected %h", f, 6'h00);
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] a, ea;
        logic [5:0] f, ef;
        logic [3:0] g2;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            txn(4'b1111, 8'b01010101, pack_idx(0, 1, 2, 3), a, f, g2);
            ea = {4'(1 << (k % 4)), 1'b1, 1'b0, 1'b0, 3'(k % 4)};
            ef = (k >= 3) ? 6'h0F : 6'((1 << (k + 1)) - 1);
            checks++;
            if (a !== ea) begin
                errors++;
                $display("FAIL rr_grant %0d: got %h, expected %h", k, a, ea);
            end
            checks++;
            if (f !== ef) begin
                errors++;
                $display("FAIL rr_flags %0d: got %h, expected %h", k, f, ef);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [9:0] a;
        logic [5:0] f;
        logic [3:0] g2;
        // Pointer is at 1 after the round-robin test.
        txn(4'b0110, 8'b0001_0100, pack_idx(0, 7, 4, 0), a, f, g2);
        checks++;
        if (a !== {4'b0010, 1'b0, 1'b0, 1'b1, 3'd7}) begin
            errors++;
            $display("FAIL oor_apply: got %h, expected %h", a, {4'b0010, 3'b001, 3'd7});
        end
        checks++;
        if (f !== 6'h0F) begin
            errors++;
            $display("FAIL oor_flags: got %h, expected %h", f, 6'h0F);
        end
        txn(4'b0110, 8'b0001_0100, pack_idx(0, 7, 4, 0), a, f, g2);
        checks++;
        if (a !== {4'b0100, 1'b1, 1'b0, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL oor_next: got %h, expected %h", a, {4'b0100, 3'b100, 3'd4});
        end
        checks++;
        if (f !== 6'h1F) begin
            errors++;
            $display("FAIL oor_next_flags: got %h, expected %h", f, 6'h1F);
        end
    endtask

    task automatic test_toggle();
        logic [9:0] a, ea1, ea2;
        logic [5:0] f, ef1, ef2;
        logic [3:0] g2;
        apply_reset();
        txn(4'b0001, 8'b01, pack_idx(2, 0, 0, 0), a, f, g2);
        checks++;
        if (f !== 6'h04) begin
            errors++;
            $display("FAIL toggle_setup: got %h, expected %h", f, 6'h04);
        end
`ifdef SR_TOGGLE_EN
        ea1 = {4'b0010, 1'b0, 1'b1, 1'b0, 3'd2}; ef1 = 6'h00;
        ea2 = {4'b0010, 1'b1, 1'b0, 1'b0, 3'd2}; ef2 = 6'h04;
`else
        ea1 = {4'b0010, 1'b0, 1'b0, 1'b1, 3'd2}; ef1 = 6'h04;
        ea2 = ea1;                                ef2 = 6'h04;
`endif
        txn(4'b0010, 8'b0000_1100, pack_idx(0, 2, 0, 0), a, f, g2);
        checks++;
        if ({a, f} !== {ea1, ef1}) begin
            errors++;
            $display("FAIL toggle_first: got %h, expected %h", {a, f}, {ea1, ef1});
        end
        txn(4'b0010, 8'b0000_1100, pack_idx(0, 2, 0, 0), a, f, g2);
        checks++;
        if ({a, f} !== {ea2, ef2}) begin
            errors++;
            $display("FAIL toggle_repeat: got %h, expected %h", {a, f}, {ea2, ef2});
        end
    endtask

    task automatic test_reset_apply();
        logic [9:0] a;
        logic [5:0] f;
        logic [3:0] g2;
        apply_reset();
        txn(4'b0010, 8'b0000_0100, pack_idx(0, 1, 0, 0), a, f, g2);
        @(negedge clk);
        req = 4'b0100; op = 8'b0001_0000; idx = pack_idx(0, 0, 5, 0);
        @(posedge clk);
        #1;
        checks++;
        if ({gnt, s_out, flag_sel} !== {4'b0100, 1'b1, 3'd5}) begin
            errors++;
            $display("FAIL rst_apply_entry: got %h, expected %h", {gnt, s_out, flag_sel},
                     {4'b0100, 1'b1, 3'd5});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, s_out, r_out, err, flag_sel} !== 10'h0) begin
            errors++;
            $display("FAIL rst_apply_async: got %h, expected %h",
                     {gnt, s_out, r_out, err, flag_sel}, 10'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (flags[5] !== 1'b0) begin
            errors++;
            $display("FAIL rst_apply_flag5: got %b, expected %b", flags[5], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = '0; op = '0; idx = '0;
        m_reset();
        txn(4'b1111, 8'b01010101, pack_idx(0, 1, 2, 3), a, f, g2);
        checks++;
        if ({a, f} !== {4'b0001, 3'b100, 3'd0, 6'h01}) begin
            errors++;
            $display("FAIL rst_apply_rr: got %h, expected %h", {a, f},
                     {4'b0001, 3'b100, 3'd0, 6'h01});
        end
    endtask

    task automatic test_random();
        logic [3:0]  rq;
        logic [7:0]  ops;
        logic [11:0] ixs;
        logic [9:0]  a, ea;
        logic [5:0]  f;
        logic [3:0]  g2;
        int          w;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            rq  = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            ops = 8'($urandom);
            ixs = 12'($urandom);
            if (rq == 4'b0000) begin
                @(negedge clk);
                req = rq; op = ops; idx = ixs;
                @(posedge clk);
                #1;
                checks++;
                if ({gnt, s_out, r_out, err, flags} !== {4'h0, 3'b000, m_vec()}) begin
                    errors++;
                    $display("FAIL rand_idle %0d: got %h, expected %h", n,
                             {gnt, s_out, r_out, err, flags}, {4'h0, 3'b000, m_vec()});
                end
            end else begin
                w  = m_winner(rq);
                ea = m_apply(w, ops, ixs);
                txn(rq, ops, ixs, a, f, g2);
                checks++;
                if (a !== ea) begin
                    errors++;
                    $display("FAIL rand_apply %0d: got %h, expected %h", n, a, ea);
                end
                m_commit(w, ea);
                checks++;
                if ({f, g2, flags_n} !== {m_vec(), 4'h0, ~m_vec()}) begin
                    errors++;
                    $display("FAIL rand_flags %0d: got %h, expected %h", n, {f, g2, flags_n},
                             {m_vec(), 4'h0, ~m_vec()});
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        op     = '0;
        idx    = '0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_set_clear();
        test_round_robin();
        test_out_of_range();
        test_toggle();
        test_reset_apply();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
